// File: rtl/state_seq_gen.sv
// state_seq_gen: 2-bit state sequencer with dwell counter, pause/abort and a
// done/ack handshake. Every 2-bit code is a defined state, so the downstream
// decode only ever sees legal registered values.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - start request, sampled only in IDLE
//   pause      - level; RUN moves to / stays in HOLD while high
//   abort      - level; returns to IDLE from any state (highest priority)
//   ack        - acknowledges done, sampled only in DONE
//   curr_state - registered state code: IDLE=0, RUN=1, HOLD=2, DONE=3
//   cnt        - registered dwell count
//   busy       - curr_state is RUN or HOLD
//   done       - curr_state is DONE
//   state_chg  - one-cycle pulse in the cycle after any curr_state change
//   timeout    - one-cycle pulse on HOLD timeout
//
// Optional feature (macro STATE_SEQ_TIMEOUT_EN): a hold counter forces
// HOLD -> IDLE after HOLD_TIMEOUT consecutive HOLD cycles and pulses timeout.
// Without the macro HOLD persists indefinitely and timeout stays 0.

module state_seq_gen #(
    parameter int RUN_CYCLES   = 8,
    parameter int CNT_W        = 4,
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             ack,
    output logic [1:0]       curr_state,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             state_chg,
    output logic             timeout
);

    if (RUN_CYCLES < 1 || RUN_CYCLES > (1 << CNT_W) || HOLD_TIMEOUT < 1) begin : g_bad_params
        $error("state_seq_gen: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);

    state_t state;
    state_t prev_state;

`ifdef STATE_SEQ_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_TIMEOUT + 1);
    // hold_cnt is the number of completed HOLD cycles before the current one,
    // so the exit fires at the end of the HOLD_TIMEOUT-th HOLD cycle.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIMEOUT - 1);
    logic [HOLD_W-1:0] hold_cnt;
`endif

    assign curr_state = state;
    assign busy       = (state == RUN) || (state == HOLD);
    assign done       = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prev_state <= IDLE;
            cnt        <= '0;
            state_chg  <= 1'b0;
            timeout    <= 1'b0;
`ifdef STATE_SEQ_TIMEOUT_EN
            hold_cnt   <= '0;
`endif
        end else begin
            // state_chg compares the two previous registered states, giving a
            // pulse one cycle after the visible change.
            prev_state <= state;
            state_chg  <= (state != prev_state);
            timeout    <= 1'b0;
            state      <= state;
            cnt        <= cnt;
`ifdef STATE_SEQ_TIMEOUT_EN
            hold_cnt   <= '0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start && !abort) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (pause) begin
                        state <= HOLD;
                    end else if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!pause) begin
                        state <= RUN;
                    end
`ifdef STATE_SEQ_TIMEOUT_EN
                    else if (hold_cnt == HOLD_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
`endif
                end
                DONE: begin
                    if (abort || ack) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_seq_gen.sv
// tb_state_seq_gen: directed scoreboard bench for state_seq_gen.
// Stimulus pushes the hand-computed expected outputs after each clock edge;
// a monitor pops and compares on the following falling edge.

module tb_state_seq_gen;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, pause, abort, ack;
    logic [1:0] curr_state;
    logic [3:0] cnt;
    logic       busy, done, state_chg, timeout;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [3:0] cnt;
        logic       chg;
        logic       to;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    state_seq_gen #(
        .RUN_CYCLES  (8),
        .CNT_W       (4),
        .HOLD_TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .ack       (ack),
        .curr_state(curr_state),
        .cnt       (cnt),
        .busy      (busy),
        .done      (done),
        .state_chg (state_chg),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [1:0] st, input logic [3:0] c,
                         input logic chg, input logic to);
        logic exp_busy;
        logic exp_done;
        exp_busy = (st == S_RUN) || (st == S_HOLD);
        exp_done = (st == S_DONE);
        n_tests++;
        if (curr_state !== st || cnt !== c || busy !== exp_busy || done !== exp_done ||
            state_chg !== chg || timeout !== to) begin
            n_fail++;
            $display("FAIL %s: got st=%0d cnt=%0d busy=%b done=%b chg=%b to=%b, want st=%0d cnt=%0d busy=%b done=%b chg=%b to=%b",
                     nm, curr_state, cnt, busy, done, state_chg, timeout,
                     st, c, exp_busy, exp_done, chg, to);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, e.st, e.cnt, e.chg, e.to);
            end
        end
    end

    // Drive inputs for one edge, then record what must be visible after it.
    task automatic step(input logic s, input logic p, input logic a, input logic k,
                        input string nm, input logic [1:0] st, input int c,
                        input logic chg, input logic to);
        exp_t e;
        start = s;
        pause = p;
        abort = a;
        ack   = k;
        @(posedge clk);
        e.name = nm;
        e.st   = st;
        e.cnt  = 4'(c);
        e.chg  = chg;
        e.to   = to;
        sb_q.push_back(e);
        #1;
    endtask

    // From a settled IDLE: start, then count up to cnt=k in RUN.
    task automatic run_to(input int k, input string nm);
        step(1, 0, 0, 0, nm, S_RUN, 0, 1'b0, 1'b0);
        for (int i = 1; i <= k; i++) begin
            step(0, 0, 0, 0, nm, S_RUN, i, (i == 1), 1'b0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset", S_IDLE, 4'd0, 1'b0, 1'b0);

        // IDLE ignores pause/ack; start with abort is refused
        step(0, 0, 0, 0, "idle",             S_IDLE, 0, 0, 0);
        step(0, 1, 0, 1, "idle_ignore",      S_IDLE, 0, 0, 0);
        step(1, 0, 1, 0, "idle_start_abort", S_IDLE, 0, 0, 0);

        // Plain run: 8 RUN cycles (cnt 0..7), then DONE; start in DONE ignored
        run_to(7, "basic_run");
        step(0, 0, 0, 0, "basic_done",        S_DONE, 7, 0, 0);
        step(1, 0, 0, 0, "done_ignore_start", S_DONE, 7, 1, 0);
        step(0, 0, 0, 0, "done_hold",         S_DONE, 7, 0, 0);
        step(0, 0, 0, 1, "basic_ack",         S_IDLE, 0, 0, 0);
        step(0, 0, 0, 0, "basic_ack_chg",     S_IDLE, 0, 1, 0);
        step(0, 0, 0, 0, "basic_idle",        S_IDLE, 0, 0, 0);

        // Pause at cnt=3 sampled on 5 edges: 5 HOLD cycles plus one resume
        // edge, so DONE arrives on edge 15 instead of edge 9.
        run_to(3, "pause_run");
        step(0, 1, 0, 0, "pause_enter", S_HOLD, 3, 0, 0);
        step(0, 1, 0, 0, "pause_hold",  S_HOLD, 3, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "pause_hold", S_HOLD, 3, 0, 0);
        step(0, 0, 0, 0, "pause_resume", S_RUN, 3, 0, 0);
        step(0, 0, 0, 0, "pause_count",  S_RUN, 4, 1, 0);
        for (int i = 5; i <= 7; i++) step(0, 0, 0, 0, "pause_count", S_RUN, i, 0, 0);
        step(0, 0, 0, 0, "pause_done",   S_DONE, 7, 0, 0);
        step(0, 0, 0, 0, "pause_done2",  S_DONE, 7, 1, 0);
        step(1, 0, 0, 1, "ack_with_start",     S_IDLE, 0, 0, 0);
        step(0, 0, 0, 0, "start_not_captured", S_IDLE, 0, 1, 0);
        step(0, 0, 0, 0, "idle_settle",        S_IDLE, 0, 0, 0);

        // abort beats pause at the last count
        run_to(7, "conf_run");
        step(0, 1, 1, 0, "abort_over_pause", S_IDLE, 0, 0, 0);
        step(0, 0, 0, 0, "abort_chg",        S_IDLE, 0, 1, 0);
        step(0, 0, 0, 0, "no_done",          S_IDLE, 0, 0, 0);

        // pause beats completion at the last count; DONE one edge after resume
        run_to(7, "last_run");
        step(0, 1, 0, 0, "pause_at_last",      S_HOLD, 7, 0, 0);
        step(0, 0, 0, 0, "release_at_last",    S_RUN,  7, 1, 0);
        step(0, 0, 0, 0, "done_after_release", S_DONE, 7, 1, 0);
        step(0, 0, 1, 0, "abort_in_done",      S_IDLE, 0, 1, 0);
        step(0, 0, 0, 0, "abort_done_chg",     S_IDLE, 0, 1, 0);
        step(0, 0, 0, 0, "idle_settle",        S_IDLE, 0, 0, 0);

        // abort while held
        run_to(2, "hold_run");
        step(0, 1, 0, 0, "hold_enter",    S_HOLD, 2, 0, 0);
        step(0, 1, 0, 0, "hold_stay",     S_HOLD, 2, 1, 0);
        step(0, 1, 1, 0, "abort_in_hold", S_IDLE, 0, 0, 0);
        step(0, 0, 0, 0, "abort_hold_chg", S_IDLE, 0, 1, 0);
        step(0, 0, 0, 0, "idle_settle",   S_IDLE, 0, 0, 0);

        // async reset between edges mid-RUN
        run_to(2, "arst_run");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", S_IDLE, 4'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 0, "after_arst",  S_IDLE, 0, 0, 0);
        step(0, 0, 0, 0, "after_arst2", S_IDLE, 0, 0, 0);

        // long pause: 20 edges
        run_to(1, "to_run");
        for (int i = 1; i <= 20; i++) begin
`ifdef STATE_SEQ_TIMEOUT_EN
            if (i <= 16)      step(0, 1, 0, 0, "to_hold",  S_HOLD, 1, (i == 2), 0);
            else if (i == 17) step(0, 1, 0, 0, "to_fire",  S_IDLE, 0, 0, 1);
            else if (i == 18) step(0, 1, 0, 0, "to_after", S_IDLE, 0, 1, 0);
            else              step(0, 1, 0, 0, "to_idle",  S_IDLE, 0, 0, 0);
`else
            step(0, 1, 0, 0, "hold_persist", S_HOLD, 1, (i == 2), 0);
`endif
        end
`ifdef STATE_SEQ_TIMEOUT_EN
        step(0, 0, 0, 0, "to_release", S_IDLE, 0, 0, 0);
        step(0, 0, 0, 0, "to_release2", S_IDLE, 0, 0, 0);
`else
        step(0, 0, 0, 0, "hold_release", S_RUN,  1, 0, 0);
        step(0, 0, 0, 0, "hold_count",   S_RUN,  2, 1, 0);
        step(0, 0, 1, 0, "final_abort",  S_IDLE, 0, 0, 0);
        step(0, 0, 0, 0, "final_idle",   S_IDLE, 0, 1, 0);
`endif

        // let the monitor drain, bounded
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got time limit reached, want normal completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
